adc_fifo_drain_scheduler: RTL and testbench

Round-robin readout controller for the 4-channel AD9228 capture block. It gates ADC capture and polls the per-channel sample FIFOs through their shared address/read-enable/data mux. Samples it pops are forwarded as channel-tagged words on a valid/ready stream toward the board readout path. When capture is disabled, it drains the remaining samples and signals completion.

---
 rtl/adc_pkg.sv | 19 +
 rtl/adc_fifo_drain_scheduler.sv | 173 +++++++++++++++++
 tb/tb_adc_fifo_drain_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants and state type for the ADC capture/readout blocks
// Purpose: keeps the capture block and the drain scheduler agreeing on channel
// count, sample width, channel-select width and the scheduler state encoding.
package adc_pkg;

  localparam int NUM_CHANNELS = 4;
  localparam int DATA_WIDTH   = 12;
  localparam int CH_W         = $clog2(NUM_CHANNELS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    CHK  = 3'd2,
    RD   = 3'd3,
    LAT  = 3'd4,
    OUT  = 3'd5
  } sched_state_t;

endpackage

// File: rtl/adc_fifo_drain_scheduler.sv
// rtl/adc_fifo_drain_scheduler.sv - round-robin FIFO drain scheduler for the AD9228 capture block
// Purpose: gates ADC capture, polls the per-channel sample FIFOs through the
// shared mux in round-robin bursts, and forwards each popped sample as a
// channel-tagged word on a valid/ready stream. Dropping enable drains the
// FIFOs and pulses done after one full pass that popped nothing.
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   enable                     1 = capture and stream, 0 = stop capture and drain
//   adc_read_en                capture enable to the AD9228 read block
//   fifo_addr, fifo_rd_en      channel select and one-hot pop to the FIFO mux
//   fifo_dout                  muxed data, valid the cycle after the pop
//   fifo_not_empty, fifo_full  muxed status of the selected channel
//   m_data, m_chan, m_valid    sample stream out, m_ready in
//   busy, done                 not idle / one-cycle drain-complete pulse
//   overflow                   sticky per-channel full seen since last start
//   sample_count               saturating count of words handed off
module adc_fifo_drain_scheduler #(
  parameter int NUM_CHANNELS = adc_pkg::NUM_CHANNELS,
  parameter int DATA_WIDTH   = adc_pkg::DATA_WIDTH,
  parameter int MAX_BURST    = 4,
  parameter int CNT_WIDTH    = 32,
  parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  output logic                    adc_read_en,
  output logic [CH_W-1:0]         fifo_addr,
  output logic [NUM_CHANNELS-1:0] fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  input  logic                    fifo_not_empty,
  input  logic                    fifo_full,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [CH_W-1:0]         m_chan,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CHANNELS-1:0] overflow,
  output logic [CNT_WIDTH-1:0]    sample_count
);

  import adc_pkg::*;

  sched_state_t            state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [7:0]              burst_q, burst_d;
  logic                    pass_clean_q, pass_clean_d;
  logic                    adc_read_en_q, adc_read_en_d;
  logic [NUM_CHANNELS-1:0] rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic [CH_W-1:0]         m_chan_q, m_chan_d;
  logic                    m_valid_q, m_valid_d;
  logic                    done_q, done_d;
  logic [NUM_CHANNELS-1:0] overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;

  logic last_ch;
  assign last_ch = (ch_q == CH_W'(NUM_CHANNELS - 1));

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    burst_d      = burst_q;
    pass_clean_d = pass_clean_q;
    rd_en_d      = '0;
    m_data_d     = m_data_q;
    m_chan_d     = m_chan_q;
    m_valid_d    = m_valid_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q;
    count_d      = count_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d      = SEL;
          ch_d         = '0;
          burst_d      = '0;
          pass_clean_d = 1'b1;
          overflow_d   = '0;
          count_d      = '0;
        end
      end
      SEL: state_d = CHK;
      CHK: begin
        if (fifo_full) begin
          overflow_d[ch_q] = 1'b1;
        end
        if (fifo_not_empty && (burst_q < 8'(MAX_BURST))) begin
          // Pop is issued from a flop so it lines up with the RD state.
          state_d       = RD;
          rd_en_d[ch_q] = 1'b1;
          pass_clean_d  = 1'b0;
        end else begin
          burst_d = '0;
          ch_d    = last_ch ? '0 : ch_q + CH_W'(1);
          state_d = SEL;
          if (last_ch) begin
            // Wrap point: a pass with no pops while draining ends the run.
            if (!enable && pass_clean_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            pass_clean_d = 1'b1;
          end
        end
      end
      RD: state_d = LAT;
      LAT: begin
        m_data_d  = fifo_dout;
        m_chan_d  = ch_q;
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          burst_d   = burst_q + 8'd1;
          if (count_q != {CNT_WIDTH{1'b1}}) begin
            count_d = count_q + CNT_WIDTH'(1);
          end
          state_d = CHK;
        end
      end
      default: state_d = IDLE;
    endcase

    adc_read_en_d = enable && (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      burst_q       <= '0;
      pass_clean_q  <= 1'b1;
      adc_read_en_q <= 1'b0;
      rd_en_q       <= '0;
      m_data_q      <= '0;
      m_chan_q      <= '0;
      m_valid_q     <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      burst_q       <= burst_d;
      pass_clean_q  <= pass_clean_d;
      adc_read_en_q <= adc_read_en_d;
      rd_en_q       <= rd_en_d;
      m_data_q      <= m_data_d;
      m_chan_q      <= m_chan_d;
      m_valid_q     <= m_valid_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      count_q       <= count_d;
    end
  end

  assign adc_read_en  = adc_read_en_q;
  assign fifo_addr    = ch_q;
  assign fifo_rd_en   = rd_en_q;
  assign m_data       = m_data_q;
  assign m_chan       = m_chan_q;
  assign m_valid      = m_valid_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign overflow     = overflow_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_adc_fifo_drain_scheduler.sv
// tb/tb_adc_fifo_drain_scheduler.sv - self-checking bench for adc_fifo_drain_scheduler
module tb_adc_fifo_drain_scheduler;

  localparam int NCH  = 4;
  localparam int DW   = 12;
  localparam int CW   = 2;
  localparam int MB   = 4;
  localparam int CNTW = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;
  logic adc_read_en;
  logic [CW-1:0] fifo_addr;
  logic [NCH-1:0] fifo_rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic fifo_not_empty, fifo_full;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_chan;
  logic m_valid, m_ready;
  logic busy, done;
  logic [NCH-1:0] overflow;
  logic [CNTW-1:0] sample_count;

  always #5 clk = ~clk;

  adc_fifo_drain_scheduler #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .adc_read_en(adc_read_en),
    .fifo_addr(fifo_addr), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_not_empty(fifo_not_empty), .fifo_full(fifo_full),
    .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .overflow(overflow), .sample_count(sample_count)
  );

  // FIFO bank behind the mux: data registered one cycle after the pop.
  logic [DW-1:0] mem [NCH][256];
  int wr_ptr [NCH] = '{0, 0, 0, 0};
  int rd_ptr [NCH] = '{0, 0, 0, 0};
  logic [NCH-1:0] full_force = '0;
  assign fifo_not_empty = (wr_ptr[fifo_addr] != rd_ptr[fifo_addr]);
  assign fifo_full = full_force[fifo_addr];

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (fifo_rd_en[i] && (wr_ptr[i] != rd_ptr[i])) begin
        fifo_dout <= mem[i][rd_ptr[i] % 256];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  // Sink readiness: random percentage or manual control.
  int ready_pct = 100;
  logic rnd_ready = 1'b1;
  bit ready_auto = 1'b1;
  logic ready_man = 1'b0;
  always @(negedge clk) rnd_ready <= ($urandom_range(99) < ready_pct);
  assign m_ready = ready_auto ? rnd_ready : ready_man;

  // Stream/pop monitor.
  logic [DW+CW-1:0] obs [$];
  int obs_t [$];
  int cyc = 0;
  int rd_cnt [NCH] = '{0, 0, 0, 0};
  int done_cnt = 0;
  int mon_err = 0;
  logic stall = 1'b0;
  logic [DW+CW-1:0] held = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn) begin
      if (m_valid && m_ready) begin
        obs.push_back({m_chan, m_data});
        obs_t.push_back(cyc);
      end
      for (int i = 0; i < NCH; i++) if (fifo_rd_en[i]) rd_cnt[i] <= rd_cnt[i] + 1;
      if (done) done_cnt <= done_cnt + 1;
      if ((fifo_rd_en != '0) && (m_valid || !$onehot(fifo_rd_en))) begin
        mon_err <= mon_err + 1;
        $display("FAIL pop_rule: fifo_rd_en=%b m_valid=%b, required one-hot pop with m_valid=0", fifo_rd_en, m_valid);
      end
      if (stall && m_valid && ({m_chan, m_data} != held)) begin
        mon_err <= mon_err + 1;
        $display("FAIL stall_hold: word=%h required %h", {m_chan, m_data}, held);
      end
    end
    stall <= rstn && m_valid && !m_ready;
    held  <= {m_chan, m_data};
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    chk(nm, {adc_read_en, fifo_addr, fifo_rd_en, m_valid, m_data, m_chan, busy, done, overflow, sample_count}, 64'd0);
  endtask

  // Reference model: contents loaded per channel; output order is visit
  // round p, then channel, then index within the channel (round = index / MB).
  logic [DW-1:0] mv [NCH][64];
  int mc [NCH] = '{0, 0, 0, 0};
  logic [DW+CW-1:0] exp_q [$];
  logic [NCH-1:0] prev_ovf = '0;
  int last_base = 0;

  task automatic push(input int c, input logic [DW-1:0] v);
    mem[c][wr_ptr[c] % 256] = v;
    wr_ptr[c] = wr_ptr[c] + 1;
    mv[c][mc[c]] = v;
    mc[c] = mc[c] + 1;
  endtask

  task automatic wait_done(input string nm);
    int tmo = 0;
    while (!done && tmo < 4000) begin
      @(negedge clk);
      tmo++;
    end
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_busy_at_done"}, busy, 0);
  endtask

  task automatic run(input string nm, input logic [NCH-1:0] full, input int pct, input bit drop_early,
                     input int exp_total, input logic [NCH-1:0] exp_ovf);
    int base, dn0, tmo;
    int rd0 [NCH];
    exp_q.delete();
    for (int p = 0; p < 64 / MB; p++)
      for (int c = 0; c < NCH; c++)
        for (int k = p * MB; (k < (p + 1) * MB) && (k < mc[c]); k++)
          exp_q.push_back({CW'(c), mv[c][k]});
    full_force = full;
    ready_pct = pct;
    ready_auto = 1'b1;
    base = obs.size();
    last_base = base;
    dn0 = done_cnt;
    rd0 = rd_cnt;
    @(negedge clk);
    chk({nm, "_ovf_sticky_idle"}, overflow, prev_ovf);
    enable = 1'b1;
    @(negedge clk);
    chk({nm, "_ovf_clear_on_start"}, overflow, 0);
    chk({nm, "_busy_start"}, {busy, adc_read_en}, 2'b11);
    if (drop_early) begin
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk({nm, "_adc_off_early"}, adc_read_en, 0);
    end else begin
      tmo = 0;
      while ((obs.size() - base < exp_total) && tmo < 4000) begin
        @(negedge clk);
        tmo++;
      end
      enable = 1'b0;
      @(negedge clk);
      chk({nm, "_adc_off"}, adc_read_en, 0);
    end
    wait_done(nm);
    chk({nm, "_sample_count"}, sample_count, exp_total);
    chk({nm, "_overflow"}, overflow, exp_ovf);
    chk({nm, "_m_valid_idle"}, m_valid, 0);
    repeat (3) @(negedge clk);
    chk({nm, "_done_pulses"}, done_cnt - dn0, 1);
    chk({nm, "_word_total"}, obs.size() - base, exp_total);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < obs.size()) chk($sformatf("%s_word%0d", nm, i), obs[base + i], exp_q[i]);
    end
    for (int c = 0; c < NCH; c++) chk($sformatf("%s_pops_ch%0d", nm, c), rd_cnt[c] - rd0[c], mc[c]);
    for (int c = 0; c < NCH; c++) mc[c] = 0;
    full_force = '0;
    prev_ovf = exp_ovf;
  endtask

  typedef struct {
    int cnt [NCH];
    logic [NCH-1:0] full;
    int pct;
    bit drop_early;
    int exp_total;
    logic [NCH-1:0] exp_ovf;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int tmo, pulses;
    logic [NCH-1:0] rf;
    int rc [NCH];
    int sum;
    vecs[0] = '{cnt: '{6, 6, 6, 6}, full: 4'b0000, pct: 100, drop_early: 1'b0, exp_total: 24, exp_ovf: 4'b0000};
    vecs[1] = '{cnt: '{0, 5, 0, 0}, full: 4'b0010, pct: 60,  drop_early: 1'b0, exp_total: 5,  exp_ovf: 4'b0010};
    vecs[2] = '{cnt: '{0, 0, 0, 1}, full: 4'b0000, pct: 100, drop_early: 1'b1, exp_total: 1,  exp_ovf: 4'b0000};
    vecs[3] = '{cnt: '{2, 0, 7, 1}, full: 4'b1001, pct: 40,  drop_early: 1'b1, exp_total: 10, exp_ovf: 4'b1001};

    rstn = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rstn = 1'b1;
    @(negedge clk);
    check_zero("idle_after_reset");

    // Channel 2 holds three known samples.
    push(2, 12'h123);
    push(2, 12'h456);
    push(2, 12'h789);
    run("ch2_three", 4'b0000, 100, 1'b0, 3, 4'b0000);
    if (obs_t.size() >= last_base + 3) begin
      chk("burst_gap_1", obs_t[last_base + 1] - obs_t[last_base], 4);
      chk("burst_gap_2", obs_t[last_base + 2] - obs_t[last_base + 1], 4);
    end else begin
      chk("burst_gap_words", obs_t.size() - last_base, 3);
    end

    for (int v = 0; v < 4; v++) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < vecs[v].cnt[c]; k++) push(c, DW'($urandom));
      run($sformatf("vec%0d", v), vecs[v].full, vecs[v].pct, vecs[v].drop_early, vecs[v].exp_total, vecs[v].exp_ovf);
    end

    for (int t = 0; t < 3; t++) begin
      sum = 0;
      for (int c = 0; c < NCH; c++) begin
        rc[c] = $urandom_range(9);
        sum += rc[c];
        for (int k = 0; k < rc[c]; k++) push(c, DW'($urandom));
      end
      rf = NCH'($urandom);
      run($sformatf("rand%0d", t), rf, $urandom_range(100, 30), 1'($urandom), sum, rf);
    end

    // Sink stalls for 10 cycles with a word held.
    push(0, 12'hABC);
    ready_auto = 1'b0;
    ready_man = 1'b0;
    enable = 1'b1;
    tmo = 0;
    while (!m_valid && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    chk("stall_valid", m_valid, 1);
    pulses = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall_hold%0d", i), {m_valid, m_chan, m_data}, {1'b1, 2'd0, 12'hABC});
    end
    chk("stall_no_pops", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3], pulses);
    ready_man = 1'b1;
    @(negedge clk);
    chk("stall_release", {m_valid, sample_count}, {1'b0, 32'd1});
    ready_auto = 1'b1;
    enable = 1'b0;
    wait_done("stall");
    for (int c = 0; c < NCH; c++) mc[c] = 0;
    prev_ovf = '0;

    // Reset while a word is held in OUT.
    push(1, 12'h5A5);
    ready_auto = 1'b0;
    ready_man = 1'b0;
    enable = 1'b1;
    tmo = 0;
    while (!m_valid && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    chk("rst_out_valid", m_valid, 1);
    rstn = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check_zero("reset_in_out");
    pulses = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("idle_after_mid_reset");
    chk("no_pop_after_reset", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3], pulses);
    for (int c = 0; c < NCH; c++) begin
      mc[c] = 0;
      wr_ptr[c] = rd_ptr[c];
    end
    ready_auto = 1'b1;

    chk("monitor_errors", mon_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
